// File: rtl/mem_channel_arbiter.sv
// rtl/mem_channel_arbiter.sv - round-robin arbiter driving one four-phase memory channel
// Grants one consumer at a time, runs its read/write to memory, then relays completion back.
module mem_channel_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CONSUMERS-1:0]       req_valid,
   input  logic [NUM_CONSUMERS-1:0]       req_write,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] req_addr,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] req_wdata,
   output logic [NUM_CONSUMERS-1:0]       resp_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] resp_rdata,
   output logic                           mem_read_valid,
   output logic [ADDR_BITS-1:0]           mem_read_address,
   input  logic                           mem_read_ready,
   input  logic [DATA_BITS-1:0]           mem_read_data,
   output logic                           mem_write_valid,
   output logic [ADDR_BITS-1:0]           mem_write_address,
   output logic [DATA_BITS-1:0]           mem_write_data,
   input  logic                           mem_write_ready,
   output logic                           busy
);
   localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

   state_t         state;
   logic [GW-1:0]  rr_ptr;
   logic [GW-1:0]  grant;
   logic           done_write;
   logic           valid_seen_low;
   logic           ready_seen_low;

   logic                 pick_found;
   logic                 pick_write;
   logic [GW-1:0]        pick_idx;
   logic [ADDR_BITS-1:0] pick_addr;
   logic [DATA_BITS-1:0] pick_wdata;
   int                   scan_idx;

   // First asserted request at or after rr_ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_write = 1'b0;
      pick_idx   = '0;
      pick_addr  = '0;
      pick_wdata = '0;
      scan_idx   = 0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_CONSUMERS)
            scan_idx = scan_idx - NUM_CONSUMERS;
         if (!pick_found && req_valid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx[GW-1:0];
            pick_write = req_write[scan_idx];
            pick_addr  = req_addr[scan_idx*ADDR_BITS +: ADDR_BITS];
            pick_wdata = req_wdata[scan_idx*DATA_BITS +: DATA_BITS];
         end
      end
   end

   logic          done_ready;
   logic          valid_low;
   logic          ready_low;
   logic [GW-1:0] next_ptr;

   // Release conditions are sticky so they may fall in either order.
   assign done_ready = done_write ? mem_write_ready : mem_read_ready;
   assign valid_low  = valid_seen_low | ~req_valid[grant];
   assign ready_low  = ready_seen_low | ~done_ready;
   assign next_ptr   = (int'(grant) == NUM_CONSUMERS - 1) ? '0 : grant + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         grant             <= '0;
         done_write        <= 1'b0;
         valid_seen_low    <= 1'b0;
         ready_seen_low    <= 1'b0;
         busy              <= 1'b0;
         resp_ready        <= '0;
         resp_rdata        <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant          <= pick_idx;
                  busy           <= 1'b1;
                  done_write     <= pick_write;
                  valid_seen_low <= 1'b0;
                  ready_seen_low <= 1'b0;
                  if (pick_write) begin
                     mem_write_valid   <= 1'b1;
                     mem_write_address <= pick_addr;
                     mem_write_data    <= pick_wdata;
                     state             <= WRITE_WAIT;
                  end else begin
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= pick_addr;
                     state            <= READ_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready) begin
                  resp_rdata[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
                  resp_ready[grant] <= 1'b1;
                  mem_read_valid    <= 1'b0;
                  state             <= RELEASE;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready) begin
                  resp_ready[grant] <= 1'b1;
                  mem_write_valid   <= 1'b0;
                  state             <= RELEASE;
               end
            end
            RELEASE: begin
               if (valid_low && ready_low) begin
                  resp_ready <= '0;
                  rr_ptr     <= next_ptr;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  valid_seen_low <= valid_low;
                  ready_seen_low <= ready_low;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb/tb_mem_channel_arbiter.sv - scoreboard bench for mem_channel_arbiter
module tb_mem_channel_arbiter;
   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_write = '0;
   logic [N*AB-1:0] req_addr = '0;
   logic [N*DB-1:0] req_wdata = '0;
   logic [N-1:0]    resp_ready;
   logic [N*DB-1:0] resp_rdata;
   logic            mem_read_valid, mem_write_valid, busy;
   logic [AB-1:0]   mem_read_address, mem_write_address;
   logic [DB-1:0]   mem_write_data;
   logic            mem_read_ready = 1'b0;
   logic            mem_write_ready = 1'b0;
   logic [DB-1:0]   mem_read_data = '0;

   always #5 clk = ~clk;

   mem_channel_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: ready after mem_lat sampled edges of valid, drops one edge after valid drops.
   logic [DB-1:0] mem_arr [256];
   logic          mem_loaded = 1'b0;
   int            mem_cnt = 0;
   int            mem_lat = 5;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int a = 0; a < 256; a++) mem_arr[a] <= '0;
         mem_arr[8'h10] <= 16'hBEEF;
         mem_loaded <= 1'b1;
      end
      if (reset) begin
         mem_read_ready  <= 1'b0;
         mem_write_ready <= 1'b0;
         mem_read_data   <= '0;
         mem_cnt         <= 0;
      end else if (mem_read_valid && !mem_read_ready) begin
         if (mem_cnt >= mem_lat - 1) begin
            mem_read_ready <= 1'b1;
            mem_read_data  <= mem_arr[mem_read_address];
            mem_cnt        <= 0;
         end else mem_cnt <= mem_cnt + 1;
      end else if (!mem_read_valid && mem_read_ready) begin
         mem_read_ready <= 1'b0;
      end else if (mem_write_valid && !mem_write_ready) begin
         if (mem_cnt >= mem_lat - 1) begin
            mem_write_ready <= 1'b1;
            mem_arr[mem_write_address] <= mem_write_data;
            mem_cnt <= 0;
         end else mem_cnt <= mem_cnt + 1;
      end else if (!mem_write_valid && mem_write_ready) begin
         mem_write_ready <= 1'b0;
      end
   end

   typedef struct {
      logic          w;
      logic [DB-1:0] d;
   } exp_t;

   exp_t          exp_q [N][$];
   int            grant_log [$];
   logic [DB-1:0] ref_mem [256];
   logic [3:0]    hold [N];

   logic [N-1:0]    snap_v = '0, snap_w = '0;
   logic [N*AB-1:0] snap_a = '0;
   logic [N*DB-1:0] snap_d = '0;
   logic            snap_rst = 1'b1;
   always @(posedge clk) begin
      snap_v   <= req_valid;
      snap_w   <= req_write;
      snap_a   <= req_addr;
      snap_d   <= req_wdata;
      snap_rst <= reset;
   end

   // Monitor: predicts each grant from the pending set and pops per-consumer expectations.
   int            model_ptr = 0;
   logic          prev_any = 1'b0;
   logic [N-1:0]  prev_resp = '0;
   logic [DB-1:0] last_rd [N];
   always @(negedge clk) begin
      int   pred, act;
      exp_t e;
      if (snap_rst) begin
         model_ptr = 0;
         prev_any  = 1'b0;
         prev_resp = '0;
         for (int i = 0; i < N; i++) last_rd[i] = '0;
      end else begin
         chk("excl_mem_valid", 64'(mem_read_valid & mem_write_valid), 64'd0);
         chk("resp_onehot", 64'($onehot0(resp_ready)), 64'd1);
         if ((mem_read_valid || mem_write_valid) && !prev_any) begin
            pred = -1;
            act  = -1;
            for (int k = 0; k < N; k++)
               if (pred < 0 && snap_v[(model_ptr + k) % N]) pred = (model_ptr + k) % N;
            for (int j = 0; j < N; j++)
               if (act < 0 && snap_v[j] && snap_w[j] == mem_write_valid &&
                   snap_a[j*AB +: AB] == (mem_write_valid ? mem_write_address : mem_read_address))
                  act = j;
            chk("grant_winner", 64'(act), 64'(pred));
            if (act >= 0 && mem_write_valid)
               chk("grant_wdata", 64'(mem_write_data), 64'(snap_d[act*DB +: DB]));
            grant_log.push_back(act);
            if (pred >= 0) model_ptr = (pred + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (resp_ready[i] && !prev_resp[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk("resp_unexpected_q_size", 64'(exp_q[i].size()), 64'd1);
               end else begin
                  e = exp_q[i].pop_front();
                  if (!e.w) begin
                     chk("resp_rdata", 64'(resp_rdata[i*DB +: DB]), 64'(e.d));
                     last_rd[i] = e.d;
                  end else begin
                     chk("resp_rdata_hold", 64'(resp_rdata[i*DB +: DB]), 64'(last_rd[i]));
                  end
               end
            end
         end
         prev_any  = mem_read_valid | mem_write_valid;
         prev_resp = resp_ready;
      end
   end

   task automatic issue(input int i, input logic w, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input int h);
      exp_t e;
      req_write[i]          = w;
      req_addr[i*AB +: AB]  = a;
      req_wdata[i*DB +: DB] = d;
      req_valid[i]          = 1'b1;
      hold[i]               = 4'(h);
      e.w = w;
      e.d = w ? d : ref_mem[a];
      if (w) ref_mem[a] = d;
      exp_q[i].push_back(e);
   endtask

   task automatic service();
      for (int i = 0; i < N; i++)
         if (req_valid[i] && resp_ready[i]) begin
            if (hold[i] == 0) req_valid[i] = 1'b0;
            else hold[i] = hold[i] - 4'd1;
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      service();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((req_valid != '0 || busy || resp_ready != '0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_idle", 64'({busy, |req_valid, |resp_ready}), 64'd0);
   endtask

   initial begin
      int n, k;
      logic [AB-1:0] ra;
      for (int a = 0; a < 256; a++) ref_mem[a] = '0;
      ref_mem[8'h10] = 16'hBEEF;
      for (int i = 0; i < N; i++) hold[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_ready", 64'(resp_ready), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("rst_mem_valid", 64'({mem_read_valid, mem_write_valid}), 64'd0);
      chk("rst_mem_bus", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
      reset = 1'b0;
      step();

      // single read, consumer 2
      issue(2, 1'b0, 8'h10, '0, 0);
      @(posedge clk);
      #1;
      chk("rd_valid", 64'(mem_read_valid), 64'd1);
      chk("rd_addr", 64'(mem_read_address), 64'h10);
      chk("rd_busy", 64'(busy), 64'd1);
      for (int c = 1; c <= 5; c++) begin
         step();
         chk("rd_resp_early", 64'(resp_ready[2]), 64'd0);
         chk("rd_busy_wait", 64'(busy), 64'd1);
      end
      step();
      chk("rd_resp_at_6", 64'(resp_ready[2]), 64'd1);
      chk("rd_rdata", 64'(resp_rdata[2*DB +: DB]), 64'hBEEF);
      drain(200);

      // write then read back, consumer 0
      issue(0, 1'b1, 8'h20, 16'h1234, 0);
      drain(200);
      issue(0, 1'b0, 8'h20, '0, 0);
      drain(200);
      chk("wr_readback", 64'(resp_rdata[0 +: DB]), 64'h1234);

      // round-robin from reset
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) issue(i, 1'b0, 8'(8'h40 + i), '0, 0);
      grant_log.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      k = 0;
      n = 0;
      while (grant_log.size() < 5 && n < 400) begin
         step();
         n++;
         if (k == 0 && !req_valid[0] && !resp_ready[0] && exp_q[0].size() == 0) begin
            issue(0, 1'b0, 8'h40, '0, 0);
            k = 1;
         end
      end
      chk("rr_log_len", 64'(grant_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         chk("rr_order", 64'(grant_log[i]), 64'(i % N));
      drain(400);

      // slow release by consumer 1, consumer 3 waiting meanwhile
      issue(1, 1'b0, 8'h11, '0, 10);
      n = 0;
      while (!resp_ready[1] && n < 100) begin
         step();
         n++;
      end
      chk("slow_resp_seen", 64'(resp_ready[1]), 64'd1);
      issue(3, 1'b0, 8'h13, '0, 0);
      k = 0;
      while (req_valid[1] && k < 40) begin
         chk("slow_resp_held", 64'(resp_ready[1]), 64'd1);
         chk("slow_no_mem_req", 64'({mem_read_valid, mem_write_valid}), 64'd0);
         chk("slow_busy", 64'(busy), 64'd1);
         step();
         k++;
      end
      chk("slow_hold_cycles", 64'(k), 64'd10);
      @(posedge clk);
      #1;
      chk("slow_idle_busy", 64'(busy), 64'd0);
      chk("slow_idle_resp", 64'(resp_ready), 64'd0);
      drain(200);

      // reset in READ_WAIT, consumer 3 re-granted afterwards
      issue(3, 1'b0, 8'h10, '0, 0);
      n = 0;
      while (!mem_read_valid && n < 20) begin
         step();
         n++;
      end
      step();
      step();
      chk("midrst_pre_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_mem_valid", 64'({mem_read_valid, mem_write_valid}), 64'd0);
      chk("midrst_resp", 64'(resp_ready), 64'd0);
      chk("midrst_rdata", 64'(resp_rdata), 64'd0);
      chk("midrst_bus", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
      reset = 1'b0;
      drain(200);
      chk("midrst_q_empty", 64'(exp_q[3].size()), 64'd0);

      // randomized traffic, addresses partitioned by consumer
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         mem_lat = $urandom_range(1, 6);
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && !resp_ready[i] && $urandom_range(0, 3) == 0) begin
               ra = {6'($urandom), 2'(i)};
               issue(i, 1'($urandom), ra, 16'($urandom), $urandom_range(0, 3));
            end
      end
      drain(500);
      for (int i = 0; i < N; i++) chk("final_q_empty", 64'(exp_q[i].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
